// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared channel geometry and FSM state encoding for the mux scan controller.
package mux_scan_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;
endpackage

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: control, mux and valid/ready signals of the scan controller.
interface mux_scan_ctrl_if #(parameter int DATA_WIDTH = 4);
  import mux_scan_pkg::*;
  logic                  start;
  logic [NUM_CH-1:0]     ch_en;
  logic [SEL_W-1:0]      sel;
  logic [DATA_WIDTH-1:0] mux_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic [SEL_W-1:0]      ch_out;
  logic                  valid;
  logic                  ready;
  logic                  busy;
  logic                  done;
  modport master (input start, ch_en, mux_out, ready,
                  output sel, data_out, ch_out, valid, busy, done);
  modport slave  (output start, ch_en, mux_out, ready,
                  input sel, data_out, ch_out, valid, busy, done);
endinterface

// File: rtl/mux_scan_next_ch.sv
// mux_scan_next_ch: lowest enabled channel strictly above cur, optionally wrapping to the lowest overall.
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [SEL_W-1:0]  cur_i,
  input  logic              wrap_i,
  output logic [SEL_W-1:0]  next_o,
  output logic              found_o
);
  always_comb begin
    next_o  = '0;
    found_o = 1'b0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (mask_i[i] && i > int'(cur_i)) begin
        next_o  = SEL_W'(i);
        found_o = 1'b1;
      end
    if (!found_o && wrap_i)
      for (int i = NUM_CH-1; i >= 0; i--)
        if (mask_i[i]) begin
          next_o  = SEL_W'(i);
          found_o = 1'b1;
        end
  end
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sweeps enabled mux channels, captures each sample and offers it on valid/ready.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int SETTLE     = 1,
  parameter int CONTINUOUS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_scan_ctrl_if.master  bus
);
  localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
  state_t                state_q;
  logic [NUM_CH-1:0]     mask_q;
  logic [SEL_W-1:0]      sel_q, ch_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CW-1:0]         cnt_q;
  logic                  valid_q, busy_q, done_q;
  logic [SEL_W-1:0]      first_d, next_d;
  logic                  first_found, next_found;
  // Starting from the top channel with wrap forced yields the lowest set bit of the raw mask.
  mux_scan_next_ch u_first (
    .mask_i (bus.ch_en),
    .cur_i  (SEL_W'(NUM_CH-1)),
    .wrap_i (1'b1),
    .next_o (first_d),
    .found_o(first_found)
  );
  mux_scan_next_ch u_next (
    .mask_i (mask_q),
    .cur_i  (sel_q),
    .wrap_i (CONTINUOUS != 0),
    .next_o (next_d),
    .found_o(next_found)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      sel_q   <= '0;
      ch_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (bus.start) begin
          if (first_found) begin
            mask_q  <= bus.ch_en;
            sel_q   <= first_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SELECT;
          end else done_q <= 1'b1;
        end
        ST_SELECT: if (cnt_q == CW'(SETTLE-1)) begin
          data_q  <= bus.mux_out;
          ch_q    <= sel_q;
          valid_q <= 1'b1;
          state_q <= ST_HOLD;
        end else cnt_q <= cnt_q + CW'(1);
        ST_HOLD: if (bus.ready) begin
          valid_q <= 1'b0;
          if (next_found) begin
            sel_q   <= next_d;
            cnt_q   <= '0;
            state_q <= ST_SELECT;
          end else begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign bus.sel      = sel_q;
  assign bus.data_out = data_q;
  assign bus.ch_out   = ch_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule
